// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel edge/center-aligned PWM with double-buffered duty and graceful stop
module pwm_multi_channel #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    center_mode,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic                    duty_valid,
  output logic                    duty_ready,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, p_act_q, p_act_d;
  logic                      dir_q, dir_d, mode_act_q, mode_act_d;
  logic                      pending_q, pending_d, first_q, first_d, tick_q, tick_d;
  logic [NUM_CH*CNT_W-1:0]   shadow_q, shadow_d, duty_act_q, duty_act_d;
  logic [NUM_CH-1:0]         pwm_q, pwm_d, cmp;
  logic                      center, wrap, boundary, accept, idle, turn;
  // period geometry: center mode with P=0 degenerates to edge mode; dir_q=1 means counting down
  always_comb begin
    idle     = state_q == IDLE;
    center   = mode_act_q && (p_act_q != '0);
    turn     = cnt_q == p_act_q - CNT_W'(1);
    wrap     = center ? (dir_q && cnt_q == '0) : (cnt_q == p_act_q);
    boundary = idle ? enable : wrap;
    accept   = duty_valid && !pending_q;
  end
  // run/stop control: a stop request only takes effect once the current period has finished
  always_comb begin
    state_d = idle ? (enable ? RUN : IDLE)
            : enable ? RUN
            : (state_q == STOP && wrap) ? IDLE : STOP;
  end
  // counter and direction; every boundary restarts at 0 counting up
  always_comb begin
    cnt_d = (idle || wrap) ? '0
          : !center ? cnt_q + CNT_W'(1)
          : dir_q ? cnt_q - CNT_W'(1)
          : turn ? cnt_q : cnt_q + CNT_W'(1);
    dir_d = !(idle || wrap) && center && (dir_q || turn);
  end
  // boundary loads and the duty shadow handshake; a boundary frees the shadow before a new accept
  always_comb begin
    p_act_d    = boundary ? period : p_act_q;
    mode_act_d = boundary ? center_mode : mode_act_q;
    duty_act_d = (boundary && pending_q) ? shadow_q : duty_act_q;
    shadow_d   = accept ? duty : shadow_q;
    pending_d  = accept || (pending_q && !boundary);
  end
  // registered outputs, forced low in IDLE and on the cycle that enters IDLE
  always_comb begin
    cmp = '0;
    for (int i = 0; i < NUM_CH; i++) cmp[i] = cnt_q < duty_act_q[i*CNT_W +: CNT_W];
    first_d = boundary && state_d != IDLE;
    tick_d  = first_q && state_d != IDLE;
    pwm_d   = (idle || state_d == IDLE) ? '0 : cmp;
  end
  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      p_act_q    <= '0;
      mode_act_q <= 1'b0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      duty_act_q <= '0;
      first_q    <= 1'b0;
      tick_q     <= 1'b0;
      pwm_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      p_act_q    <= p_act_d;
      mode_act_q <= mode_act_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      duty_act_q <= duty_act_d;
      first_q    <= first_d;
      tick_q     <= tick_d;
      pwm_q      <= pwm_d;
    end
  end
  assign duty_ready  = !pending_q;
  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign busy        = !idle;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: scoreboard bench; stimulus queues per-period expectations, monitor checks at each tick
module tb_pwm_multi_channel;
  localparam int NC = 3;
  localparam int W  = 8;
  logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, center_mode = 1'b0, duty_valid = 1'b0;
  logic [W-1:0]  period = '0;
  logic [NC*W-1:0] duty = '0;
  logic          duty_ready, period_tick, busy;
  logic [NC-1:0] pwm_out;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {int len; int h0; int h1; int h2;} exp_t;
  exp_t sb[$];

  pwm_multi_channel #(.NUM_CH(NC), .CNT_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .center_mode(center_mode),
    .period(period), .duty(duty), .duty_valid(duty_valid), .duty_ready(duty_ready),
    .pwm_out(pwm_out), .period_tick(period_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick;
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < 40);
    chk("tick_arrival", int'(period_tick), 1);
  endtask

  task automatic push(input int len, input int h0, input int h1, input int h2);
    sb.push_back('{len: len, h0: h0, h1: h1, h2: h2});
  endtask

  function automatic logic [NC*W-1:0] pk(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  // monitor: accumulates each period between ticks and compares against the queued expectation
  initial begin
    bit   act;
    int   len;
    int   h[NC];
    exp_t e;
    act = 0;
    len = 0;
    foreach (h[i]) h[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) act = 0;
      else begin
        if (period_tick) begin
          if (act) begin
            if (sb.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL sb_underflow: period of %0d cycles closed with no expectation", len);
            end else begin
              e = sb.pop_front();
              chk("period_len", len, e.len);
              chk("ch0_high", h[0], e.h0);
              chk("ch1_high", h[1], e.h1);
              chk("ch2_high", h[2], e.h2);
            end
          end
          act = 1;
          len = 0;
          foreach (h[i]) h[i] = 0;
        end else if (!busy) act = 0;
        if (act) begin
          len++;
          foreach (h[i]) h[i] += int'(pwm_out[i]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // stimulus
  initial begin
    int n;
    logic [7:0] pat;
    pat = 8'b1100_0011;
    #2;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(duty_ready), 1);
    #10 reset_n = 1'b1;
    step();
    duty = pk(0, 5, 12);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    chk("ready_after_accept", int'(duty_ready), 0);
    period = 8'd9;
    enable = 1'b1;
    repeat (3) push(10, 0, 5, 10);
    step();
    chk("ready_after_start", int'(duty_ready), 1);
    chk("busy_after_start", int'(busy), 1);
    repeat (4) wait_tick();
    push(10, 0, 5, 10);
    push(10, 7, 7, 7);
    push(10, 1, 1, 1);
    step();
    step();
    duty = pk(7, 7, 7);
    duty_valid = 1'b1;
    step();
    chk("ready_while_pending", int'(duty_ready), 0);
    duty = pk(1, 1, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!duty_ready && n < 30);
    chk("holdoff_cycles", n, 6);
    chk("tick_after_ready", int'(period_tick), 0);
    step();
    chk("second_accept", int'(duty_ready), 0);
    chk("tick_lags_boundary", int'(period_tick), 1);
    duty_valid = 1'b0;
    wait_tick();
    wait_tick();
    step();
    step();
    step();
    period = 8'd4;
    push(10, 1, 1, 1);
    push(5, 1, 1, 1);
    push(5, 1, 1, 1);
    wait_tick();
    wait_tick();
    center_mode = 1'b1;
    duty = pk(2, 4, 0);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    chk("center_duty_pending", int'(duty_ready), 0);
    push(8, 4, 8, 0);
    push(8, 4, 8, 0);
    push(10, 2, 4, 0);
    push(10, 2, 4, 0);
    wait_tick();
    wait_tick();
    period = 8'd9;
    center_mode = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("center_pattern", int'(pwm_out[0]), int'(pat[7-j]));
      if (j < 7) step();
    end
    wait_tick();
    step();
    step();
    enable = 1'b0;
    repeat (3) step();
    chk("busy_in_stop", int'(busy), 1);
    enable = 1'b1;
    wait_tick();
    wait_tick();
    step();
    n = 1;
    enable = 1'b0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    chk("stop_cycles", n, 9);
    chk("stop_pwm", int'(pwm_out), 0);
    chk("stop_tick", int'(period_tick), 0);
    chk("stop_ready", int'(duty_ready), 1);
    repeat (5) begin
      step();
      chk("stays_idle", int'(busy), 0);
      chk("idle_no_tick", int'(period_tick), 0);
    end
    duty = pk(9, 9, 9);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    chk("idle_accept", int'(duty_ready), 0);
    enable = 1'b1;
    wait_tick();
    duty = pk(3, 3, 3);
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    chk("pending_before_reset", int'(duty_ready), 0);
    repeat (4) step();
    chk("pwm_before_reset", int'(pwm_out), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pwm", int'(pwm_out), 0);
    chk("async_ready", int'(duty_ready), 1);
    chk("async_busy", int'(busy), 0);
    chk("async_tick", int'(period_tick), 0);
    enable = 1'b0;
    step();
    step();
    #3 reset_n = 1'b1;
    repeat (3) step();
    chk("idle_after_reset", int'(busy), 0);
    enable = 1'b1;
    push(10, 0, 0, 0);
    wait_tick();
    wait_tick();
    enable = 1'b0;
    repeat (12) step();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
